multi_lane_register: RTL
========================

# multi_lane_register

Parametrised successor to the two-byte word register. It assembles a `LANES × LANE_W` word from a narrow `DIN` bus, either by explicit lane enables or by an auto-incrementing lane pointer. Completion is tracked with a FULL/ACK handshake and an overrun flag. It sits between byte-wide sources (instruction fetch, UART/SPI receive, memory byte reads) and word-wide consumers in the ForthCPU datapath.

## Interface
- `LANE_W`, 8, width of one lane and of `DIN`
- `LANES`, 2, number of lanes (≥2; need not be a power of 2)
- `MSB_FIRST`, 0, sequential fill order: 0 = lane 0 first, 1 = lane `LANES-1` first

- `CLK`  in  1  clock; all state changes on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `LD`  in  1  explicit load: write `DIN` into every lane whose `EN` bit is 1
- `EN`  in  `LANES`  lane enables, used only when `LD`=1
- `SEQ`  in  1  sequential load: write `DIN` into the lane selected by `PTR`, then advance `PTR`
- `ACK`  in  1  consumer acknowledge: clears fill tracking, `PTR`, `FULL`, `OVERRUN`
- `DIN`  in  `LANE_W`  lane data
- `DOUT`  out  `LANES*LANE_W`  assembled word; lane i = `DOUT[i*LANE_W +: LANE_W]`
- `PTR`  out  `max(1,clog2(LANES))`  next sequential fill position (0 … `LANES-1`)
- `WRITTEN`  out  `LANES`  per-lane written-since-ACK mask
- `FULL`  out  1  all lanes written since last ACK/reset
- `OVERRUN`  out  1  sticky: a write occurred while `FULL`=1

## Operation
- Reset (`RESET`=1 at an edge): `DOUT`=0, `PTR`=0, `WRITTEN`=0, `FULL`=0, `OVERRUN`=0. RESET overrides all other inputs, including mid-fill.
- Priority per cycle: RESET > ACK clear > LD > SEQ. When `LD`=`SEQ`=1, LD is performed, SEQ is ignored, and `PTR` is unchanged.
- LD: lane i <= `DIN` for each `EN[i]`=1. `WRITTEN` |= `EN`. `PTR` is unchanged. `LD`=1 with `EN`=0 is a no-op. `EN` is ignored when `LD`=0.
- SEQ (`LD`=0): the physical lane is `PTR` (`MSB_FIRST`=0) or `LANES-1-PTR` (`MSB_FIRST`=1). That lane <= `DIN` and its `WRITTEN` bit is set. `PTR` <= `PTR`=`LANES-1` ? 0 : `PTR`+1. The wrap is an explicit compare, not modulo-2^n.
- ACK: `WRITTEN`, `PTR`, `FULL`, `OVERRUN` are cleared. `DOUT` is retained.
- ACK with a write in the same cycle: clear first, then apply the write.
  - LD: `WRITTEN` <= `EN`.
  - SEQ: writes the pointer-0 lane; `PTR` <= 1; `WRITTEN` <= that lane's bit.
  - `FULL` <= &(new `WRITTEN`). `OVERRUN` <= 0.
- `FULL` <= &(next `WRITTEN`), registered.
- `OVERRUN` <= 1 on any LD (nonzero `EN`) or SEQ write while `FULL`=1 and `ACK`=0. The data is still written.
- Lanes not addressed by a write hold their value.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- Write latency is 1 cycle: `DOUT`, `PTR`, `WRITTEN`, `FULL`, `OVERRUN` reflect the write after the sampling edge.
- `FULL` rises on the same edge as the completing lane write. Consumer may sample `DOUT` in the cycle `FULL`=1.
- Handshake: the consumer asserts `ACK` for one cycle while `FULL`=1. An `ACK` when `FULL`=0 simply restarts the fill.
- Back-to-back `SEQ` is allowed every cycle. A full `LANES`-lane fill takes exactly `LANES` cycles.

## Test plan
- Reset dominance: `RESET`=1 with `LD`=1, `EN`=all, `DIN`=8'haa -> `DOUT`=0, `PTR`=0, `WRITTEN`=0, `FULL`=0, `OVERRUN`=0.
- LANES=2 lane-enable compatibility:
  - `LD`=0 with `EN`=11 -> `DOUT`=16'h0000.
  - `LD`=1, `EN`=01, `DIN`=aa -> 16'h00aa, `FULL`=0.
  - `EN`=10, `DIN`=55 -> 16'h55aa, `FULL`=1.
  - `LD`=1, `EN`=00 -> unchanged.
- LANES=4 sequential fill:
  - `SEQ` with `DIN`=11,22,33,44 -> `PTR` 1,2,3,0; `DOUT`=32'h44332211; `FULL`=1 after the 4th edge only.
  - With `MSB_FIRST`=1 -> 32'h11223344.
- Overrun/ACK (continuing LANES=4):
  - `SEQ`, `DIN`=55 while `FULL` -> `DOUT`=32'h44332255, `OVERRUN`=1, `PTR`=1.
  - `ACK` -> `FULL`=0, `OVERRUN`=0, `PTR`=0, `WRITTEN`=0, `DOUT` unchanged.
- Simultaneous events:
  - `ACK`+`SEQ`, `DIN`=66, `PTR`=2 -> lane0=66, `PTR`=1, `WRITTEN`=0001, `FULL`=0.
  - `LD`(`EN`=1000)+`SEQ` -> only lane3 written, `PTR` unchanged.
- Non-power-of-2, LANES=3: 4 `SEQ` writes a,b,c,d -> `PTR` 1,2,0,1; `DOUT`=24'h0c0b0d (lane0 overwritten by 0d, lane1=0b, lane2=0c); `FULL`=1 after the 3rd write, `OVERRUN`=1 after the 4th.

Source files
------------

// File: rtl/multi_lane_register.sv
// Assembles a LANES x LANE_W word from a narrow DIN bus, by explicit lane
// enables or an auto-incrementing lane pointer, with FULL/ACK/OVERRUN tracking.
module multi_lane_register #(
  parameter int LANE_W    = 8,
  parameter int LANES     = 2,
  parameter int MSB_FIRST = 0,
  localparam int PW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    LD,
  input  logic [LANES-1:0]        EN,
  input  logic                    SEQ,
  input  logic                    ACK,
  input  logic [LANE_W-1:0]       DIN,
  output logic [LANES*LANE_W-1:0] DOUT,
  output logic [PW-1:0]           PTR,
  output logic [LANES-1:0]        WRITTEN,
  output logic                    FULL,
  output logic                    OVERRUN
);

  logic [PW-1:0]    ptr_base;
  logic [PW-1:0]    ptr_nxt;
  logic [PW-1:0]    seq_lane;
  logic [LANES-1:0] written_base;
  logic [LANES-1:0] written_nxt;
  logic [LANES-1:0] lane_we;
  logic             do_seq;
  logic             overrun_nxt;

  // ACK clears tracking first; any write in the same cycle then lands on the cleared state.
  always_comb begin
    ptr_base     = ACK ? '0 : PTR;
    written_base = ACK ? '0 : WRITTEN;
    do_seq       = SEQ && !LD;
    seq_lane     = (MSB_FIRST != 0) ? (PW'(LANES - 1) - ptr_base) : ptr_base;

    lane_we = '0;
    if (LD) begin
      lane_we = EN;
    end else if (do_seq) begin
      for (int i = 0; i < LANES; i++) begin
        if (seq_lane == PW'(i)) lane_we[i] = 1'b1;
      end
    end

    written_nxt = written_base | lane_we;

    ptr_nxt = ptr_base;
    if (do_seq) begin
      ptr_nxt = (ptr_base == PW'(LANES - 1)) ? '0 : ptr_base + 1'b1;
    end

    overrun_nxt = ACK ? 1'b0 : (OVERRUN || (FULL && (|lane_we)));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      DOUT    <= '0;
      PTR     <= '0;
      WRITTEN <= '0;
      FULL    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) DOUT[i*LANE_W +: LANE_W] <= DIN;
      end
      PTR     <= ptr_nxt;
      WRITTEN <= written_nxt;
      FULL    <= &written_nxt;
      OVERRUN <= overrun_nxt;
    end
  end

endmodule
